pipe_hazard_ctrl: RTL

//  Hazard and stall sequencer for the 5-stage pipeline. Produces stall and flush enables for the F, F/D, D/E, E/M and M/W pipeline registers.

---
 rtl/pipe_hazard_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard, forwarding, branch-flush and data-memory wait sequencer
module pipe_hazard_ctrl #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       rtdE,
    input  logic [4:0]       rtdM,
    input  logic [4:0]       rtdW,
    input  logic             rfweE,
    input  logic             rfweM,
    input  logic             rfweW,
    input  logic             mtorfselE,
    input  logic             mtorfselM,
    input  logic             dmweM,
    input  logic             branchM,
    input  logic             zeroM,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic             pcsrcM,
    output logic [1:0]       fwdAE,
    output logic [1:0]       fwdBE,
    output logic             mem_busy,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int WCNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state, stateNext;
    logic [WCNT_W-1:0] wcnt, wcntNext;
    logic              memacc, memstall, lwstall;

    function automatic logic [1:0] fwdSel(input logic [4:0] src);
        if (rfweM && rtdM != 5'd0 && rtdM == src)
            return 2'b10;
        else if (rfweW && rtdW != 5'd0 && rtdW == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign fwdAE    = fwdSel(rsE);
    assign fwdBE    = fwdSel(rtE);
    assign pcsrcM   = branchM & zeroM;
    assign memacc   = mtorfselM | dmweM;
    assign lwstall  = mtorfselE && rfweE && rtdE != 5'd0 && (rtdE == rsD || rtdE == rtD);
    assign mem_busy = (state == WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= stateNext;
            wcnt  <= wcntNext;
        end
    end

    // wcnt counts the remaining stalled cycles after the first; zero in WAIT marks completion.
    always_comb begin
        stateNext = state;
        wcntNext  = wcnt;
        memstall  = 1'b0;
        case (state)
            IDLE: begin
                if (memacc && MEM_LAT > 1) begin
                    memstall  = 1'b1;
                    stateNext = WAIT;
                    wcntNext  = WCNT_INIT;
                end
            end
            WAIT: begin
                if (wcnt != '0) begin
                    memstall = 1'b1;
                    wcntNext = wcnt - WCNT_W'(1);
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // A memory wait freezes everything and wins over load-use and branch handling.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        flushW = 1'b0;
        if (memstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else begin
            stallF = lwstall & ~pcsrcM;
            stallD = lwstall & ~pcsrcM;
            flushE = lwstall | pcsrcM;
            flushD = pcsrcM;
            flushM = pcsrcM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stallF && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end
endmodule
